gon_collect_bus: RTL and testbench
==================================

Name: gon_collect_bus

Overview:
- Output-direction companion of the GIN multicast bus: a global output network row collector.
- Gathers partial-sum words from up to MASTER_NUMS PEs in one PE-array row.
- Tags each word with the source slot's scan-configured ID and forwards one word per cycle upstream to the GLB.
- Uses the same packed {enable, tag, value} upstream format as the GIN bus, with ready/enable handshakes on both sides.

Parameters:
- MASTER_NUMS, 14, number of PE source slots in the row.
- ID_LEN, 5, tag/ID width.
- VALUE_LEN, 32, data word width.
- MA_Y, 0, row index; informational only, no functional effect.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- master_enable_data  input  MASTER_NUMS*(VALUE_LEN+1)  source i at [i*(VALUE_LEN+1) +: VALUE_LEN+1]; MSB of each slice is enable, low VALUE_LEN bits are value.
- master_ready  output  MASTER_NUMS  grant/ready to each source; one-hot or zero.
- ready  input  1  upstream consumer ready.
- enable_tag_value  output  VALUE_LEN+ID_LEN+1  {enable, tag, value} to upstream.
- set_id  input  1  scan-chain shift enable.
- id_scan_in  input  ID_LEN  scan-chain input.
- id_scan_out  output  ID_LEN  scan-chain output (last slot's ID).

Behaviour:
- Reset (async, immediate, no clock needed):
  - out_valid=0, out_tag=0, out_value=0, rr_ptr=0, all id_reg=0.
  - master_ready=0 and id_scan_out=0.
  - Any in-flight word is dropped.
- ID scan chain, on each clk edge with set_id=1:
  - id_reg[0]<=id_scan_in; id_reg[i]<=id_reg[i-1] for i=1..MASTER_NUMS-1.
  - id_scan_out=id_reg[MASTER_NUMS-1], registered.
  - Duplicate IDs are legal.
- Output register (out_valid, out_tag, out_value):
  - enable_tag_value={out_valid, out_tag, out_value}.
  - Upstream transfer occurs when out_valid && ready.
  - While out_valid && !ready, all output bits are held stable.
  - When out_valid=0, tag/value hold their last loaded contents (don't-care).
- can_load = (!out_valid || ready) && !set_id.
- Arbitration (combinational, same cycle):
  - Round-robin over requesting slots (enable bit=1), searching from rr_ptr upward with wrap-around; first requester wins.
  - If can_load and a winner g exists: master_ready[g]=1; all other master_ready bits are 0.
  - Otherwise master_ready is all 0.
- A source transfer occurs when enable && master_ready same cycle. On that edge:
  - out_value<=value_g, out_tag<=id_reg[g], out_valid<=1.
  - rr_ptr<=(g+1) mod MASTER_NUMS.
- If an upstream transfer occurs with no source transfer: out_valid<=0, rr_ptr unchanged.
- Simultaneous upstream drain and new grant are allowed. Result: back-to-back throughput of 1 word/cycle.
- Latency: exactly 1 cycle from source handshake to the word appearing on enable_tag_value.
- set_id=1 blocks new grants. A pending output word may still drain during set_id.
- Sources must hold enable/value until granted. Dropping enable before grant is permitted; that slot simply loses its turn.
- A ready input with out_valid=0 has no effect.

Decomposition:
- Shared package/header: default widths (ID_LEN, VALUE_LEN), field position constants for the packed {enable, tag, value} word, and slice macros for the {enable, value} source format. All of these are shared with the GIN bus.
- One natural sub-module: gon_rr_arbiter. It is parameterized N. Inputs: req[N], ptr, en. Outputs: one-hot gnt and binary gnt_idx.

Test Plan (MASTER_NUMS=4, ID_LEN=5, VALUE_LEN=32):
- Scan chain: set_id=1 for 4 cycles with id_scan_in=3,2,1,0 -> id_reg[0..3]=0,1,2,3, id_scan_out=3. During the shift, requests on all slots -> master_ready stays 0000.
- Single source: slot2 enable=1, value=32'hDEADBEEF, ready=1 -> master_ready=0100 same cycle. Next cycle enable_tag_value={1, 5'd2, 32'hDEADBEEF}. Cycle after (no requests) enable=0.
- Fairness: all 4 slots requesting continuously, ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one upstream word every cycle, tags 0,1,2,3,0.
- Backpressure: word from slot1 pending, ready=0 for 3 cycles with slot3 requesting -> enable_tag_value frozen {1, 1, value1}, master_ready=0000. Raise ready -> slot1 word drains and master_ready=1000 in the same cycle; slot3 word is valid the next cycle.
- Reset mid-operation: assert rst between clock edges while out_valid=1 -> enable_tag_value=0 and master_ready=0 immediately. After release, the first grant starts from slot0.
- Wrap: rr_ptr=3 with slots 0 and 3 requesting -> slot3 granted first, then slot0.

Source files
------------

// File: rtl/gon_collect_bus_pkg.sv
// Shared GIN/GON definitions: default widths and field positions of the packed
// {enable, tag, value} upstream word and of the {enable, value} source slices.
package gon_collect_bus_pkg;

   localparam int GON_ID_LEN    = 5;
   localparam int GON_VALUE_LEN = 32;

   function automatic int etv_width(input int id_len, input int value_len);
      return value_len + id_len + 1;
   endfunction

   function automatic int etv_enable_pos(input int id_len, input int value_len);
      return value_len + id_len;
   endfunction

   function automatic int etv_tag_lo(input int value_len);
      return value_len;
   endfunction

   function automatic int src_slice_w(input int value_len);
      return value_len + 1;
   endfunction

   function automatic int src_slice_lo(input int slot, input int value_len);
      return slot * (value_len + 1);
   endfunction

   function automatic int src_enable_pos(input int slot, input int value_len);
      return slot * (value_len + 1) + value_len;
   endfunction

endpackage

// File: rtl/gon_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (wrapping) wins.
// Latency: combinational. Backpressure: en=0 suppresses the grant, gnt_idx still valid.
// Backpressure: no internal state; caller advances ptr after a consumed grant.
module gon_rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      found   = 1'b0;
      for (int off = 0; off < N; off++) begin
         idx = PW'((int'(ptr) + off) % N);
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
      if (en && found) begin
         gnt[gnt_idx] = 1'b1;
         gnt_vld      = 1'b1;
      end
   end

endmodule

// File: rtl/gon_collect_bus.sv
// GON row collector: round-robin gathers PE words, tags them with scanned IDs.
// Latency: 1 cycle source handshake to upstream word; 1 word/cycle sustained.
// Backpressure: upstream !ready freezes the output word and withholds all grants.
module gon_collect_bus
   import gon_collect_bus_pkg::*;
#(
   parameter int MASTER_NUMS = 14,
   parameter int ID_LEN      = GON_ID_LEN,
   parameter int VALUE_LEN   = GON_VALUE_LEN,
   parameter int MA_Y        = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [MASTER_NUMS*(VALUE_LEN+1)-1:0]   master_enable_data,
   output logic [MASTER_NUMS-1:0]                 master_ready,
   input  logic                                   ready,
   output logic [VALUE_LEN+ID_LEN:0]              enable_tag_value,
   input  logic                                   set_id,
   input  logic [ID_LEN-1:0]                      id_scan_in,
   output logic [ID_LEN-1:0]                      id_scan_out
);

   localparam int PW = (MASTER_NUMS > 1) ? $clog2(MASTER_NUMS) : 1;

   if (MA_Y < 0) begin : g_bad_row
      $error("gon_collect_bus: MA_Y must be non-negative");
   end

   logic [MASTER_NUMS-1:0] req;
   logic [VALUE_LEN-1:0]   src_value [MASTER_NUMS];
   logic [ID_LEN-1:0]      id_reg    [MASTER_NUMS];
   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          gnt_idx;
   logic                   gnt_vld;
   logic                   can_load;
   logic                   out_valid;
   logic [ID_LEN-1:0]      out_tag;
   logic [VALUE_LEN-1:0]   out_value;

   for (genvar i = 0; i < MASTER_NUMS; i++) begin : g_src
      assign req[i]       = master_enable_data[src_enable_pos(i, VALUE_LEN)];
      assign src_value[i] = master_enable_data[src_slice_lo(i, VALUE_LEN) +: VALUE_LEN];
   end

   // rst gates grants so master_ready drops the instant reset is asserted
   assign can_load = (!out_valid || ready) && !set_id && !rst;

   gon_rr_arbiter #(
      .N  (MASTER_NUMS),
      .PW (PW)
   ) u_arb (
      .req     (req),
      .ptr     (rr_ptr),
      .en      (can_load),
      .gnt     (master_ready),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MASTER_NUMS; i++) id_reg[i] <= '0;
      end else if (set_id) begin
         id_reg[0] <= id_scan_in;
         for (int i = 1; i < MASTER_NUMS; i++) id_reg[i] <= id_reg[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_value <= '0;
         rr_ptr    <= '0;
      end else if (gnt_vld) begin
         out_valid <= 1'b1;
         out_tag   <= id_reg[gnt_idx];
         out_value <= src_value[gnt_idx];
         rr_ptr    <= (gnt_idx == PW'(MASTER_NUMS - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_valid && ready) begin
         out_valid <= 1'b0;
      end
   end

   assign enable_tag_value = {out_valid, out_tag, out_value};
   assign id_scan_out      = id_reg[MASTER_NUMS-1];

endmodule

// File: tb/tb_gon_collect_bus.sv
// Directed bench for gon_collect_bus with four source slots.
module tb_gon_collect_bus;

   localparam int N  = 4;
   localparam int IL = 5;
   localparam int VL = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [N*(VL+1)-1:0] med;
   logic [N-1:0]      mr;
   logic              ready;
   logic [VL+IL:0]    etv;
   logic              set_id;
   logic [IL-1:0]     id_scan_in;
   logic [IL-1:0]     id_scan_out;

   int errors = 0;
   int checks = 0;

   gon_collect_bus #(
      .MASTER_NUMS (N),
      .ID_LEN      (IL),
      .VALUE_LEN   (VL),
      .MA_Y        (0)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .master_enable_data (med),
      .master_ready       (mr),
      .ready              (ready),
      .enable_tag_value   (etv),
      .set_id             (set_id),
      .id_scan_in         (id_scan_in),
      .id_scan_out        (id_scan_out)
   );

   always #5 clk = ~clk;

   task automatic set_src(input int i, input logic en, input logic [VL-1:0] v);
      med[i*(VL+1) +: VL+1] = {en, v};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [VL+IL:0] exp_etv;
      rst = 1'b1; ready = 1'b1; set_id = 1'b0; id_scan_in = '0; med = '0;
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 32'h1000 + i);
      #2;
      exp_etv = '0;
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL reset_etv: got %h expected %h", etv, exp_etv); end
      checks++; if (mr !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", mr); end
      checks++; if (id_scan_out !== 5'd0) begin errors++; $display("FAIL reset_scan_out: got %0d expected 0", id_scan_out); end
      step();
      step();
      rst = 1'b0;
      med = '0;
   endtask

   task automatic test_scan();
      int vals[4] = '{3, 2, 1, 0};
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 32'h2000 + i);
      set_id = 1'b1;
      for (int k = 0; k < 4; k++) begin
         id_scan_in = IL'(vals[k]);
         #1;
         checks++; if (mr !== 4'b0000) begin errors++; $display("FAIL scan_no_grant[%0d]: got %b expected 0000", k, mr); end
         step();
         if (k == 2) begin
            checks++; if (id_scan_out !== 5'd0) begin errors++; $display("FAIL scan_out_mid: got %0d expected 0", id_scan_out); end
         end
      end
      checks++; if (id_scan_out !== 5'd3) begin errors++; $display("FAIL scan_out_final: got %0d expected 3", id_scan_out); end
      checks++; if (etv[VL+IL] !== 1'b0) begin errors++; $display("FAIL scan_no_output: got %b expected 0", etv[VL+IL]); end
      set_id = 1'b0;
      med = '0;
   endtask

   task automatic test_single();
      logic [VL+IL:0] exp_etv;
      ready = 1'b1;
      set_src(2, 1'b1, 32'hDEADBEEF);
      #1;
      checks++; if (mr !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", mr); end
      step();
      set_src(2, 1'b0, 32'h0);
      exp_etv = {1'b1, 5'd2, 32'hDEADBEEF};
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL single_word: got %h expected %h", etv, exp_etv); end
      step();
      checks++; if (etv[VL+IL] !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", etv[VL+IL]); end
   endtask

   // rr_ptr is 3 here after the slot2 grant
   task automatic test_wrap();
      logic [VL+IL:0] exp_etv;
      set_src(0, 1'b1, 32'hA0A0A0A0);
      set_src(3, 1'b1, 32'hA3A3A3A3);
      #1;
      checks++; if (mr !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b expected 1000", mr); end
      step();
      set_src(3, 1'b0, 32'h0);
      #1;
      exp_etv = {1'b1, 5'd3, 32'hA3A3A3A3};
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL wrap_word3: got %h expected %h", etv, exp_etv); end
      checks++; if (mr !== 4'b0001) begin errors++; $display("FAIL wrap_second: got %b expected 0001", mr); end
      step();
      set_src(0, 1'b0, 32'h0);
      exp_etv = {1'b1, 5'd0, 32'hA0A0A0A0};
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL wrap_word0: got %h expected %h", etv, exp_etv); end
      step();
   endtask

   // rr_ptr is 1 here
   task automatic test_backpressure();
      logic [VL+IL:0] exp_etv;
      ready = 1'b1;
      set_src(1, 1'b1, 32'hB1B1B1B1);
      #1;
      checks++; if (mr !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b expected 0010", mr); end
      step();
      set_src(1, 1'b0, 32'h0);
      ready = 1'b0;
      set_src(3, 1'b1, 32'hB3B3B3B3);
      exp_etv = {1'b1, 5'd1, 32'hB1B1B1B1};
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (etv !== exp_etv) begin errors++; $display("FAIL bp_hold[%0d]: got %h expected %h", k, etv, exp_etv); end
         checks++; if (mr !== 4'b0000) begin errors++; $display("FAIL bp_no_grant[%0d]: got %b expected 0000", k, mr); end
         step();
      end
      ready = 1'b1;
      #1;
      checks++; if (mr !== 4'b1000) begin errors++; $display("FAIL bp_release_grant: got %b expected 1000", mr); end
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL bp_release_word: got %h expected %h", etv, exp_etv); end
      step();
      set_src(3, 1'b0, 32'h0);
      exp_etv = {1'b1, 5'd3, 32'hB3B3B3B3};
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL bp_word3: got %h expected %h", etv, exp_etv); end
      step();
      checks++; if (etv[VL+IL] !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", etv[VL+IL]); end
   endtask

   // rr_ptr is 0 here
   task automatic test_back_to_back();
      int exp_slot[5] = '{0, 1, 2, 3, 0};
      logic [VL-1:0] vals[4] = '{32'hF0000000, 32'hF1111111, 32'hF2222222, 32'hF3333333};
      logic [VL+IL:0] exp_etv;
      logic [N-1:0] exp_mr;
      ready = 1'b1;
      for (int i = 0; i < N; i++) set_src(i, 1'b1, vals[i]);
      for (int k = 0; k < 5; k++) begin
         #1;
         exp_mr = '0;
         exp_mr[exp_slot[k]] = 1'b1;
         checks++; if (mr !== exp_mr) begin errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, mr, exp_mr); end
         step();
         exp_etv = {1'b1, IL'(exp_slot[k]), vals[exp_slot[k]]};
         checks++; if (etv !== exp_etv) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", k, etv, exp_etv); end
      end
      med = '0;
      step();
      checks++; if (etv[VL+IL] !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", etv[VL+IL]); end
   endtask

   task automatic test_reset_midop();
      logic [VL+IL:0] exp_etv;
      ready = 1'b1;
      set_src(2, 1'b1, 32'hC2C2C2C2);
      step();
      set_src(2, 1'b0, 32'h0);
      ready = 1'b0;
      checks++; if (etv[VL+IL] !== 1'b1) begin errors++; $display("FAIL midop_pending: got %b expected 1", etv[VL+IL]); end
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 32'hD0 + i);
      #2;
      rst = 1'b1;
      #1;
      exp_etv = '0;
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL midop_etv: got %h expected %h", etv, exp_etv); end
      checks++; if (mr !== 4'b0000) begin errors++; $display("FAIL midop_ready: got %b expected 0000", mr); end
      #1;
      rst = 1'b0;
      #1;
      checks++; if (mr !== 4'b0001) begin errors++; $display("FAIL midop_first_grant: got %b expected 0001", mr); end
      step();
      exp_etv = {1'b1, 5'd0, 32'h000000D0};
      checks++; if (etv !== exp_etv) begin errors++; $display("FAIL midop_word: got %h expected %h", etv, exp_etv); end
      med = '0;
      ready = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_scan();
      test_single();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
